// File: rtl/operand_entry.sv
// operand_entry: conditions raw buttons and digit switches into a BCD operand, sign and enter/clear strobes
// Ports:
//   i_clk, i_rst_n                       clock, asynchronous active-low reset
//   i_digit                              BCD digit switches, sampled on a push press
//   i_push_btn/i_enter_btn/i_clear_btn   raw buttons: shift digit in, commit, clear
//   i_sign_btn                           raw button: toggles sign (only with OPERAND_ENTRY_SIGN_EN)
//   o_val, o_sign                        BCD operand (LS digit in [3:0]) and sign, 1 = negative
//   o_enter, o_clear, o_digit_err        one-cycle strobes
//   o_count, o_full                      significant digits entered, operand full
// Build option: define OPERAND_ENTRY_SIGN_EN to build the sign button path; otherwise o_sign is 0.
module operand_entry #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int DIGITS = 10
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [3:0]            i_digit,
   input  logic                  i_push_btn,
   input  logic                  i_enter_btn,
   input  logic                  i_clear_btn,
   input  logic                  i_sign_btn,
   output logic [4*DIGITS-1:0]   o_val,
   output logic                  o_sign,
   output logic                  o_enter,
   output logic                  o_clear,
   output logic [3:0]            o_count,
   output logic                  o_full,
   output logic                  o_digit_err
);
`ifdef OPERAND_ENTRY_SIGN_EN
   localparam int NB = 4;
   logic [NB-1:0] raw;
   assign raw = {i_sign_btn, i_clear_btn, i_enter_btn, i_push_btn};
`else
   localparam int NB = 3;
   logic [NB-1:0] raw;
   logic          unused_sign;
   assign raw = {i_clear_btn, i_enter_btn, i_push_btn};
   assign unused_sign = i_sign_btn;
`endif
   localparam int CW = $clog2(DEBOUNCE_CYCLES);

   logic [NB-1:0] rise, press_q;

   for (genvar b = 0; b < NB; b++) begin : g_btn
      logic          s1_q, s2_q, lvl_q, lvl_d, prev_q;
      logic [CW-1:0] cnt_q, cnt_d;
      // accepted level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
      always_comb begin
         lvl_d = lvl_q;
         cnt_d = '0;
         if (s2_q != lvl_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) lvl_d = s2_q;
            else cnt_d = cnt_q + 1'b1;
         end
      end
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            lvl_q  <= 1'b0;
            prev_q <= 1'b0;
            cnt_q  <= '0;
         end else begin
            s1_q   <= raw[b];
            s2_q   <= s1_q;
            lvl_q  <= lvl_d;
            prev_q <= lvl_q;
            cnt_q  <= cnt_d;
         end
      end
      assign rise[b] = lvl_q & ~prev_q;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) press_q <= '0;
      else press_q <= rise;
   end

   typedef enum logic [1:0] {EMPTY, ENTRY, FULL, COMMITTED} state_e;

   state_e               st_q, st_d;
   logic [4*DIGITS-1:0]  val_q, val_d;
   logic [3:0]           cnt_q, cnt_d;
   logic                 sign_q, sign_d, enter_q, enter_d, clear_q, clear_d, err_q, err_d;

   // priority: clear > enter > push > sign; losers in the same cycle are dropped
   always_comb begin
      st_d    = st_q;
      val_d   = val_q;
      cnt_d   = cnt_q;
      sign_d  = sign_q;
      enter_d = 1'b0;
      clear_d = 1'b0;
      err_d   = 1'b0;
      if (press_q[2]) begin
         st_d    = EMPTY;
         val_d   = '0;
         cnt_d   = 4'd0;
         sign_d  = 1'b0;
         clear_d = 1'b1;
      end else if (press_q[1]) begin
         st_d    = COMMITTED;
         enter_d = 1'b1;
      end else if (press_q[0]) begin
         if (i_digit > 4'd9 || st_q == FULL) err_d = 1'b1;
         else if (st_q == COMMITTED) begin
            sign_d = 1'b0;
            val_d  = (4*DIGITS)'(i_digit);
            cnt_d  = (i_digit == 4'd0) ? 4'd0 : 4'd1;
            st_d   = (i_digit == 4'd0) ? EMPTY : ENTRY;
         end else if (!(st_q == EMPTY && i_digit == 4'd0)) begin
            val_d = {val_q[4*DIGITS-5:0], i_digit};
            cnt_d = cnt_q + 4'd1;
            st_d  = (cnt_d == 4'(DIGITS)) ? FULL : ENTRY;
         end
      end
`ifdef OPERAND_ENTRY_SIGN_EN
      else if (press_q[3]) begin
         sign_d = ~sign_q;
         if (st_q == COMMITTED) st_d = (cnt_q == 4'(DIGITS)) ? FULL : ENTRY;
      end
`endif
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         st_q    <= EMPTY;
         val_q   <= '0;
         cnt_q   <= 4'd0;
         sign_q  <= 1'b0;
         enter_q <= 1'b0;
         clear_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         st_q    <= st_d;
         val_q   <= val_d;
         cnt_q   <= cnt_d;
         sign_q  <= sign_d;
         enter_q <= enter_d;
         clear_q <= clear_d;
         err_q   <= err_d;
      end
   end

   assign o_val       = val_q;
   assign o_sign      = sign_q;
   assign o_enter     = enter_q;
   assign o_clear     = clear_q;
   assign o_count     = cnt_q;
   assign o_full      = (cnt_q == 4'(DIGITS));
   assign o_digit_err = err_q;
endmodule

// File: tb/tb_operand_entry.sv
// tb_operand_entry: self-checking bench for operand_entry (DEBOUNCE_CYCLES = 4)
module tb_operand_entry;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  i_digit = 4'd0;
   logic        i_push_btn = 1'b0, i_enter_btn = 1'b0, i_clear_btn = 1'b0, i_sign_btn = 1'b0;
   logic [39:0] o_val;
   logic        o_sign, o_enter, o_clear, o_full, o_digit_err;
   logic [3:0]  o_count;

   operand_entry #(.DEBOUNCE_CYCLES(4), .DIGITS(10)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_digit(i_digit),
      .i_push_btn(i_push_btn), .i_enter_btn(i_enter_btn),
      .i_clear_btn(i_clear_btn), .i_sign_btn(i_sign_btn),
      .o_val(o_val), .o_sign(o_sign), .o_enter(o_enter), .o_clear(o_clear),
      .o_count(o_count), .o_full(o_full), .o_digit_err(o_digit_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0;
   int n_enter = 0, n_clear = 0, n_err = 0;
   int g_enter, g_clear, g_err;

   always @(negedge clk) begin
      n_enter += int'(o_enter);
      n_clear += int'(o_clear);
      n_err   += int'(o_digit_err);
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // one debounced press of the chosen buttons; strobes seen during it land in g_*
   task automatic press(input logic p, input logic e, input logic c, input logic s,
                        input logic [3:0] d, input int hold);
      int e0, c0, r0;
      e0 = n_enter; c0 = n_clear; r0 = n_err;
      @(negedge clk);
      i_digit = d; i_push_btn = p; i_enter_btn = e; i_clear_btn = c; i_sign_btn = s;
      repeat (hold) @(negedge clk);
      i_push_btn = 0; i_enter_btn = 0; i_clear_btn = 0; i_sign_btn = 0;
      repeat (12) @(negedge clk);
      g_enter = n_enter - e0; g_clear = n_clear - c0; g_err = n_err - r0;
   endtask

   // reference model: operand as a list of entered digits
   localparam int M_EMPTY = 0, M_ENTRY = 1, M_COMMIT = 2;
   int m_digs[$];
   int m_mode = M_EMPTY;
   bit m_sign = 0;

   task automatic m_apply(input bit p, input bit e, input bit c, input bit s, input int d,
                          output int xe, output int xc, output int xr);
      xe = 0; xc = 0; xr = 0;
      if (c) begin
         m_digs.delete(); m_sign = 0; m_mode = M_EMPTY; xc = 1;
      end else if (e) begin
         m_mode = M_COMMIT; xe = 1;
      end else if (p) begin
         if (d > 9 || (m_mode != M_COMMIT && m_digs.size() == 10)) xr = 1;
         else if (m_mode == M_COMMIT) begin
            m_sign = 0;
            m_digs.delete();
            if (d != 0) m_digs.push_back(d);
            m_mode = (d != 0) ? M_ENTRY : M_EMPTY;
         end else if (!(m_mode == M_EMPTY && d == 0)) begin
            m_digs.push_back(d);
            m_mode = M_ENTRY;
         end
      end
`ifdef OPERAND_ENTRY_SIGN_EN
      else if (s) begin
         m_sign = !m_sign;
         if (m_mode == M_COMMIT) m_mode = M_ENTRY;
      end
`endif
   endtask

   function automatic logic [39:0] m_val();
      logic [39:0] v = '0;
      foreach (m_digs[i]) v = v * 16 + 40'(m_digs[i]);
      return v;
   endfunction

   typedef struct {
      logic p, e, c;
      logic [3:0] d;
      logic [39:0] val;
      int cnt;
      logic full, ent, clr, err;
   } vec_t;
   vec_t tbl[25];

   initial begin
      int changes, xe, xc, xr, r, dd;
      logic [3:0] last_cnt;
      logic p, e, c, s;
      bit stable;

      tbl = '{
         '{0,0,1, 4'd0, 40'h0,          0, 0,0,1,0},
         '{1,0,0, 4'd0, 40'h0,          0, 0,0,0,0},
         '{1,0,0, 4'd1, 40'h1,          1, 0,0,0,0},
         '{1,0,0, 4'd2, 40'h12,         2, 0,0,0,0},
         '{1,0,0, 4'd3, 40'h123,        3, 0,0,0,0},
         '{1,0,0, 4'd4, 40'h1234,       4, 0,0,0,0},
         '{1,0,0, 4'd5, 40'h12345,      5, 0,0,0,0},
         '{1,0,0, 4'd6, 40'h123456,     6, 0,0,0,0},
         '{1,0,0, 4'd7, 40'h1234567,    7, 0,0,0,0},
         '{1,0,0, 4'd8, 40'h12345678,   8, 0,0,0,0},
         '{1,0,0, 4'd9, 40'h123456789,  9, 0,0,0,0},
         '{1,0,0, 4'd9, 40'h1234567899, 10, 1,0,0,0},
         '{1,0,0, 4'd5, 40'h1234567899, 10, 1,0,0,1},
         '{0,1,0, 4'd0, 40'h1234567899, 10, 1,1,0,0},
         '{1,0,0, 4'd4, 40'h4,          1, 0,0,0,0},
         '{1,0,0, 4'd2, 40'h42,         2, 0,0,0,0},
         '{0,1,0, 4'd0, 40'h42,         2, 0,1,0,0},
         '{1,0,0, 4'd5, 40'h5,          1, 0,0,0,0},
         '{1,0,0, 4'hA, 40'h5,          1, 0,0,0,1},
         '{0,1,1, 4'd0, 40'h0,          0, 0,0,1,0},
         '{0,1,0, 4'd0, 40'h0,          0, 0,1,0,0},
         '{1,0,0, 4'd0, 40'h0,          0, 0,0,0,0},
         '{1,0,0, 4'd0, 40'h0,          0, 0,0,0,0},
         '{1,1,0, 4'd6, 40'h0,          0, 0,1,0,0},
         '{1,0,0, 4'd6, 40'h6,          1, 0,0,0,0}
      };

      repeat (3) @(negedge clk);
      chk("reset_val", o_val, 0);
      chk("reset_flags", {o_sign, o_enter, o_clear, o_full, o_digit_err, o_count}, 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // press latency: hold push 20 cycles with digit 7
      i_digit = 4'd7; i_push_btn = 1'b1;
      changes = 0; last_cnt = o_count;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (o_count !== last_cnt) changes++;
         last_cnt = o_count;
         if (k == 6) chk("latency_before", o_count, 0);
         if (k == 7) chk("latency_at", {o_val, o_count}, {40'h7, 4'd1});
      end
      i_push_btn = 1'b0;
      repeat (12) @(negedge clk);
      chk("latency_one_update", changes, 1);

      // bounce rejection: toggle every 2 cycles, then hold
      i_digit = 4'd3; stable = 1;
      for (int t = 0; t < 12; t++) begin
         i_push_btn = (t % 4) < 2;
         @(negedge clk);
         if (o_count !== 4'd1) stable = 0;
      end
      repeat (6) @(negedge clk) if (o_count !== 4'd1) stable = 0;
      chk("bounce_no_accept", stable, 1);
      i_push_btn = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (k == 6) chk("bounce_before", o_count, 1);
         if (k == 7) chk("bounce_accept", {o_val, o_count}, {40'h73, 4'd2});
      end
      i_push_btn = 1'b0;
      repeat (12) @(negedge clk);

      // directed vectors
      foreach (tbl[i]) begin
         press(tbl[i].p, tbl[i].e, tbl[i].c, 1'b0, tbl[i].d, 8 + (i % 4));
         chk($sformatf("vec%0d_val", i), o_val, tbl[i].val);
         chk($sformatf("vec%0d_cnt", i), {o_full, o_sign, o_count}, {tbl[i].full, 1'b0, 4'(tbl[i].cnt)});
         chk($sformatf("vec%0d_strobes", i), {g_enter, g_clear, g_err},
             {int'(tbl[i].ent), int'(tbl[i].clr), int'(tbl[i].err)});
      end

      // reset mid-debounce
      press(0, 0, 1, 0, 4'd0, 8);
      press(1, 0, 0, 0, 4'd4, 8);
      press(1, 0, 0, 0, 4'd2, 8);
`ifdef OPERAND_ENTRY_SIGN_EN
      press(0, 0, 0, 1, 4'd0, 8);
      chk("pre_reset", {o_val, o_sign}, {40'h42, 1'b1});
`else
      chk("pre_reset", {o_val, o_sign}, {40'h42, 1'b0});
`endif
      @(negedge clk);
      i_digit = 4'd9; i_push_btn = 1'b1;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0; i_push_btn = 1'b0;
      #1 chk("async_reset", {o_val, o_sign, o_enter, o_clear, o_full, o_digit_err, o_count}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      xe = n_enter; xc = n_clear; xr = n_err;
      repeat (20) @(negedge clk);
      chk("post_reset_quiet", {n_enter - xe, n_clear - xc, n_err - xr}, 0);
      chk("post_reset_val", {o_val, o_count}, 0);

      // randomized presses against the model
      for (int n = 0; n < 150; n++) begin
         r = $urandom_range(0, 19);
         dd = $urandom_range(0, 11);
         p = (r <= 11) || r >= 18;
         e = (r >= 12 && r <= 14) || r >= 18;
         c = (r == 15) || (r == 19);
         s = (r == 16) || (r == 17);
         press(p, e, c, s, 4'(dd), $urandom_range(8, 14));
         m_apply(p, e, c, s, dd, xe, xc, xr);
         chk($sformatf("rnd%0d_val", n), o_val, m_val());
         chk($sformatf("rnd%0d_cnt", n), {o_full, o_count}, {m_digs.size() == 10, 4'(m_digs.size())});
         chk($sformatf("rnd%0d_sign", n), o_sign, m_sign);
         chk($sformatf("rnd%0d_strobes", n), {g_enter, g_clear, g_err}, {xe, xc, xr});
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
